age_select_tree: RTL and testbench

//  Parametrised, pipelined N-way magnitude compare-select. Finds the minimum (oldest) or

---
 rtl/age_select_tree_pkg.sv | 12 +
 rtl/age_select_tree_if.sv | 33 +++
 rtl/age_select_tree_node.sv | 45 ++++
 rtl/age_select_tree.sv | 151 +++++++++++++++
 tb/tb_age_select_tree.sv | 297 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/age_select_tree_pkg.sv
// rtl/age_select_tree_pkg.sv - shared constants and tree-indexing helper for the age select tree
package age_select_tree_pkg;

  localparam int ROB_TAG_W   = 8;
  localparam int DEF_ENTRIES = 8;

  // Nodes are numbered heap-style: root is 1, children of n are 2n and 2n+1.
  function automatic int node_depth(input int n);
    return $clog2(n + 1) - 1;
  endfunction

endpackage

// File: rtl/age_select_tree_if.sv
// rtl/age_select_tree_if.sv - request/result handshake bundle for the age select tree
interface age_select_tree_if
  import age_select_tree_pkg::*;
#(
  parameter int WIDTH   = ROB_TAG_W,
  parameter int ENTRIES = DEF_ENTRIES
);
  localparam int LEVELS = $clog2(ENTRIES);

  logic                       in_valid;
  logic                       in_ready;
  logic [ENTRIES*WIDTH-1:0]   in_keys;
  logic [ENTRIES-1:0]         in_lane_vld;
  logic [WIDTH-1:0]           in_base;
  logic                       in_wrap;
  logic                       in_find_max;
  logic                       out_valid;
  logic                       out_ready;
  logic                       out_found;
  logic [WIDTH-1:0]           out_key;
  logic [LEVELS-1:0]          out_index;

  modport master (
    output in_valid, in_keys, in_lane_vld, in_base, in_wrap, in_find_max, out_ready,
    input  in_ready, out_valid, out_found, out_key, out_index
  );

  modport slave (
    input  in_valid, in_keys, in_lane_vld, in_base, in_wrap, in_find_max, out_ready,
    output in_ready, out_valid, out_found, out_key, out_index
  );

endinterface

// File: rtl/age_select_tree_node.sv
// rtl/age_select_tree_node.sv - combinational 2-input compare-select node (age_cmp_node)
module age_cmp_node
  import age_select_tree_pkg::*;
#(
  parameter int WIDTH = ROB_TAG_W,
  parameter int IDXW  = 3
) (
  input  logic             find_max,
  input  logic             a_pres,
  input  logic [WIDTH-1:0] a_eff,
  input  logic [WIDTH-1:0] a_orig,
  input  logic [IDXW-1:0]  a_idx,
  input  logic             b_pres,
  input  logic [WIDTH-1:0] b_eff,
  input  logic [WIDTH-1:0] b_orig,
  input  logic [IDXW-1:0]  b_idx,
  output logic             y_pres,
  output logic [WIDTH-1:0] y_eff,
  output logic [WIDTH-1:0] y_orig,
  output logic [IDXW-1:0]  y_idx
);

  logic b_better;
  logic pick_b;

  // Side a always holds the lower lane indices, so ties fall to a.
  always_comb begin
    b_better = find_max ? (b_eff > a_eff) : (b_eff < a_eff);
    pick_b   = b_pres & (~a_pres | b_better);
    y_pres   = a_pres | b_pres;
    y_eff    = '0;
    y_orig   = '0;
    y_idx    = '0;
    if (pick_b) begin
      y_eff  = b_eff;
      y_orig = b_orig;
      y_idx  = b_idx;
    end else if (a_pres) begin
      y_eff  = a_eff;
      y_orig = a_orig;
      y_idx  = a_idx;
    end
  end

endmodule

// File: rtl/age_select_tree.sv
// rtl/age_select_tree.sv - pipelined N-way min/max (oldest/youngest) select with wrap-relative keys
module age_select_tree
  import age_select_tree_pkg::*;
#(
  parameter int WIDTH   = ROB_TAG_W,
  parameter int ENTRIES = DEF_ENTRIES
) (
  input logic             clk,
  input logic             rst_n,
  age_select_tree_if.slave bus
);

  localparam int LEVELS = $clog2(ENTRIES);
  localparam int IDXW   = LEVELS;

  logic stall;
  logic en;

  logic             lf_pres [ENTRIES];
  logic [WIDTH-1:0] lf_eff  [ENTRIES];
  logic [WIDTH-1:0] lf_orig [ENTRIES];
  logic [IDXW-1:0]  lf_idx  [ENTRIES];

  logic             nd_pres [1:ENTRIES-1];
  logic [WIDTH-1:0] nd_eff  [1:ENTRIES-1];
  logic [WIDTH-1:0] nd_orig [1:ENTRIES-1];
  logic [IDXW-1:0]  nd_idx  [1:ENTRIES-1];

  logic             pres_d [1:ENTRIES-1];
  logic             pres_q [1:ENTRIES-1];
  logic [WIDTH-1:0] eff_d  [1:ENTRIES-1];
  logic [WIDTH-1:0] eff_q  [1:ENTRIES-1];
  logic [WIDTH-1:0] orig_d [1:ENTRIES-1];
  logic [WIDTH-1:0] orig_q [1:ENTRIES-1];
  logic [IDXW-1:0]  idx_d  [1:ENTRIES-1];
  logic [IDXW-1:0]  idx_q  [1:ENTRIES-1];

  logic vld_d  [1:LEVELS];
  logic vld_q  [1:LEVELS];
  logic fmax_d [1:LEVELS];
  logic fmax_q [1:LEVELS];

  assign stall        = vld_q[LEVELS] & ~bus.out_ready;
  assign en           = ~stall;
  assign bus.in_ready = en;

  // Gating presence with in_valid makes bubbles travel as all-absent trees.
  for (genvar i = 0; i < ENTRIES; i++) begin : g_leaf
    assign lf_orig[i] = bus.in_keys[i*WIDTH +: WIDTH];
    assign lf_eff[i]  = bus.in_wrap ? (lf_orig[i] - bus.in_base) : lf_orig[i];
    assign lf_pres[i] = bus.in_lane_vld[i] & bus.in_valid;
    assign lf_idx[i]  = IDXW'(i);
  end

  for (genvar n = 1; n < ENTRIES; n++) begin : g_node
    logic             a_pres, b_pres, fmax;
    logic [WIDTH-1:0] a_eff, b_eff, a_orig, b_orig;
    logic [IDXW-1:0]  a_idx, b_idx;

    if (2 * n >= ENTRIES) begin : g_from_leaf
      assign a_pres = lf_pres[2*n-ENTRIES];
      assign a_eff  = lf_eff[2*n-ENTRIES];
      assign a_orig = lf_orig[2*n-ENTRIES];
      assign a_idx  = lf_idx[2*n-ENTRIES];
      assign b_pres = lf_pres[2*n+1-ENTRIES];
      assign b_eff  = lf_eff[2*n+1-ENTRIES];
      assign b_orig = lf_orig[2*n+1-ENTRIES];
      assign b_idx  = lf_idx[2*n+1-ENTRIES];
      assign fmax   = bus.in_find_max;
    end else begin : g_from_reg
      assign a_pres = pres_q[2*n];
      assign a_eff  = eff_q[2*n];
      assign a_orig = orig_q[2*n];
      assign a_idx  = idx_q[2*n];
      assign b_pres = pres_q[2*n+1];
      assign b_eff  = eff_q[2*n+1];
      assign b_orig = orig_q[2*n+1];
      assign b_idx  = idx_q[2*n+1];
      assign fmax   = fmax_q[LEVELS-1-node_depth(n)];
    end

    age_cmp_node #(.WIDTH(WIDTH), .IDXW(IDXW)) u_node (
      .find_max (fmax),
      .a_pres   (a_pres),
      .a_eff    (a_eff),
      .a_orig   (a_orig),
      .a_idx    (a_idx),
      .b_pres   (b_pres),
      .b_eff    (b_eff),
      .b_orig   (b_orig),
      .b_idx    (b_idx),
      .y_pres   (nd_pres[n]),
      .y_eff    (nd_eff[n]),
      .y_orig   (nd_orig[n]),
      .y_idx    (nd_idx[n])
    );
  end

  always_comb begin
    for (int n = 1; n < ENTRIES; n++) begin
      pres_d[n] = pres_q[n];
      eff_d[n]  = eff_q[n];
      orig_d[n] = orig_q[n];
      idx_d[n]  = idx_q[n];
      if (en) begin
        pres_d[n] = nd_pres[n];
        eff_d[n]  = nd_eff[n];
        orig_d[n] = nd_orig[n];
        idx_d[n]  = nd_idx[n];
      end
    end
    vld_d[1]  = en ? bus.in_valid    : vld_q[1];
    fmax_d[1] = en ? bus.in_find_max : fmax_q[1];
    for (int s = 2; s <= LEVELS; s++) begin
      vld_d[s]  = en ? vld_q[s-1]  : vld_q[s];
      fmax_d[s] = en ? fmax_q[s-1] : fmax_q[s];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int n = 1; n < ENTRIES; n++) begin
        pres_q[n] <= 1'b0;
        eff_q[n]  <= '0;
        orig_q[n] <= '0;
        idx_q[n]  <= '0;
      end
      for (int s = 1; s <= LEVELS; s++) begin
        vld_q[s]  <= 1'b0;
        fmax_q[s] <= 1'b0;
      end
    end else begin
      for (int n = 1; n < ENTRIES; n++) begin
        pres_q[n] <= pres_d[n];
        eff_q[n]  <= eff_d[n];
        orig_q[n] <= orig_d[n];
        idx_q[n]  <= idx_d[n];
      end
      for (int s = 1; s <= LEVELS; s++) begin
        vld_q[s]  <= vld_d[s];
        fmax_q[s] <= fmax_d[s];
      end
    end
  end

  assign bus.out_valid = vld_q[LEVELS];
  assign bus.out_found = pres_q[1];
  assign bus.out_key   = orig_q[1];
  assign bus.out_index = idx_q[1];

endmodule

// File: tb/tb_age_select_tree.sv
// tb/tb_age_select_tree.sv - self-checking bench for age_select_tree (8 lanes x 8 bits)
module tb_age_select_tree;

  typedef struct {
    logic [63:0] keys;
    logic [7:0]  vld;
    logic [7:0]  base;
    logic        wrap;
    logic        fmax;
  } req_t;

  typedef struct {
    logic       found;
    logic [7:0] key;
    logic [2:0] idx;
  } res_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   passes;

  age_select_tree_if #(.WIDTH(8), .ENTRIES(8)) bif ();

  age_select_tree #(.WIDTH(8), .ENTRIES(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Linear scan: first lane holding the best relative age wins.
  function automatic res_t model(input req_t r);
    res_t m;
    int   best;
    int   k;
    int   e;
    m.found = 1'b0;
    m.key   = '0;
    m.idx   = '0;
    best    = 0;
    for (int i = 0; i < 8; i++) begin
      if (r.vld[i]) begin
        k = int'(r.keys[i*8 +: 8]);
        e = r.wrap ? ((k - int'(r.base) + 256) % 256) : k;
        if (!m.found || (r.fmax ? (e > best) : (e < best))) begin
          m.found = 1'b1;
          best    = e;
          m.key   = 8'(k);
          m.idx   = 3'(i);
        end
      end
    end
    return m;
  endfunction

  function automatic req_t rand_req();
    req_t r;
    r.base = 8'($urandom);
    r.wrap = 1'($urandom);
    r.fmax = 1'($urandom);
    r.vld  = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
    for (int i = 0; i < 8; i++)
      r.keys[i*8 +: 8] = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 5)) : 8'($urandom);
    return r;
  endfunction

  function automatic req_t mk_req(input logic [63:0] keys, input logic [7:0] vld,
                                  input logic [7:0] base, input logic wrap, input logic fmax);
    req_t r;
    r.keys = keys;
    r.vld  = vld;
    r.base = base;
    r.wrap = wrap;
    r.fmax = fmax;
    return r;
  endfunction

  task automatic drive(input req_t r, input logic v);
    bif.in_valid    = v;
    bif.in_keys     = r.keys;
    bif.in_lane_vld = r.vld;
    bif.in_base     = r.base;
    bif.in_wrap     = r.wrap;
    bif.in_find_max = r.fmax;
  endtask

  task automatic test_reset();
    req_t r;
    res_t e;
    int   seen;
    rst_n         = 1'b0;
    bif.out_ready = 1'b1;
    drive(rand_req(), 1'b1);
    repeat (2) @(posedge clk);
    #1;
    checks++; if (bif.out_valid !== 1'b0) $display("FAIL reset out_valid: got %b expected 0", bif.out_valid); else passes++;
    checks++; if (bif.out_found !== 1'b0) $display("FAIL reset out_found: got %b expected 0", bif.out_found); else passes++;
    checks++; if (bif.out_key !== 8'd0) $display("FAIL reset out_key: got %0d expected 0", bif.out_key); else passes++;
    checks++; if (bif.out_index !== 3'd0) $display("FAIL reset out_index: got %0d expected 0", bif.out_index); else passes++;
    checks++; if (bif.in_ready !== 1'b1) $display("FAIL reset in_ready: got %b expected 1", bif.in_ready); else passes++;
    rst_n = 1'b1;
    r = rand_req();
    r.vld = r.vld | 8'h01;
    e = model(r);
    drive(r, 1'b1);
    @(posedge clk); #1;
    drive(rand_req(), 1'b1);
    @(posedge clk); #1;
    drive(rand_req(), 1'b0);
    @(posedge clk); #1;
    checks++; if (bif.out_valid !== 1'b1 || bif.out_key !== e.key)
      $display("FAIL pre_reset result: got valid %b key %0d expected valid 1 key %0d", bif.out_valid, bif.out_key, e.key);
    else passes++;
    #2 rst_n = 1'b0;
    #1;
    checks++; if (bif.out_valid !== 1'b0) $display("FAIL async_reset out_valid: got %b expected 0", bif.out_valid); else passes++;
    @(posedge clk); #1;
    rst_n = 1'b1;
    seen = 0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      if (bif.out_valid === 1'b1) seen++;
    end
    checks++; if (seen !== 0) $display("FAIL post_reset results: got %0d expected 0", seen); else passes++;
  endtask

  task automatic test_directed();
    req_t       dr   [6];
    logic       x_f  [6];
    logic [7:0] x_k  [6];
    logic [2:0] x_i  [6];
    logic [63:0] ks;
    logic [63:0] wk;
    ks = {8'd1, 8'd6, 8'd5, 8'd12, 8'd3, 8'd9, 8'd3, 8'd7};
    wk = {40'd0, 8'd251, 8'd254, 8'd2};
    dr[0] = mk_req(ks, 8'hFF, 8'd0,   1'b0, 1'b0); x_f[0] = 1; x_k[0] = 8'd1;   x_i[0] = 3'd7;
    dr[1] = mk_req(ks, 8'h7F, 8'd0,   1'b0, 1'b0); x_f[1] = 1; x_k[1] = 8'd3;   x_i[1] = 3'd1;
    dr[2] = mk_req(ks, 8'hFF, 8'd0,   1'b0, 1'b1); x_f[2] = 1; x_k[2] = 8'd12;  x_i[2] = 3'd4;
    dr[3] = mk_req(wk, 8'h07, 8'd250, 1'b1, 1'b0); x_f[3] = 1; x_k[3] = 8'd251; x_i[3] = 3'd2;
    dr[4] = mk_req(wk, 8'h07, 8'd250, 1'b0, 1'b0); x_f[4] = 1; x_k[4] = 8'd2;   x_i[4] = 3'd0;
    dr[5] = mk_req(ks, 8'h00, 8'd0,   1'b0, 1'b0); x_f[5] = 0; x_k[5] = 8'd0;   x_i[5] = 3'd0;
    bif.out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      drive(dr[k], 1'b1);
      @(posedge clk); #1;
      drive(rand_req(), 1'b0);
      @(posedge clk); #2;
      checks++; if (bif.out_valid !== 1'b0) $display("FAIL dir%0d early_valid: got %b expected 0", k, bif.out_valid); else passes++;
      @(posedge clk); #2;
      checks++; if (bif.out_valid !== 1'b1) $display("FAIL dir%0d out_valid: got %b expected 1", k, bif.out_valid); else passes++;
      checks++; if (bif.out_found !== x_f[k]) $display("FAIL dir%0d out_found: got %b expected %b", k, bif.out_found, x_f[k]); else passes++;
      checks++; if (bif.out_key !== x_k[k]) $display("FAIL dir%0d out_key: got %0d expected %0d", k, bif.out_key, x_k[k]); else passes++;
      checks++; if (bif.out_index !== x_i[k]) $display("FAIL dir%0d out_index: got %0d expected %0d", k, bif.out_index, x_i[k]); else passes++;
    end
  endtask

  task automatic test_back_to_back();
    req_t reqs [5];
    res_t q [$];
    res_t e;
    int   sent;
    int   got;
    logic held;
    logic       p_found;
    logic [7:0] p_key;
    logic [2:0] p_idx;
    for (int i = 0; i < 5; i++) begin
      reqs[i] = rand_req();
      reqs[i].vld = reqs[i].vld | 8'h10;
    end
    sent = 0;
    got  = 0;
    held = 1'b0;
    p_found = 1'b0; p_key = '0; p_idx = '0;
    for (int c = 0; c < 60 && got < 5; c++) begin
      @(posedge clk); #1;
      bif.out_ready = !(c >= 4 && c < 8);
      if (sent < 5) drive(reqs[sent], 1'b1); else drive(rand_req(), 1'b0);
      #1;
      if (c >= 4 && c < 8) begin
        checks++; if (bif.in_ready !== 1'b0) $display("FAIL b2b stall_in_ready c%0d: got %b expected 0", c, bif.in_ready); else passes++;
        checks++; if (bif.out_valid !== 1'b1) $display("FAIL b2b stall_out_valid c%0d: got %b expected 1", c, bif.out_valid); else passes++;
      end
      if (held) begin
        checks++;
        if ({bif.out_found, bif.out_key, bif.out_index} !== {p_found, p_key, p_idx})
          $display("FAIL b2b hold c%0d: got %b/%0d/%0d expected %b/%0d/%0d", c,
                   bif.out_found, bif.out_key, bif.out_index, p_found, p_key, p_idx);
        else passes++;
      end
      if (bif.out_valid === 1'b1) begin
        checks++;
        if (q.size() == 0) $display("FAIL b2b unexpected result c%0d: got key %0d expected none", c, bif.out_key);
        else begin
          e = q[0];
          if ({bif.out_found, bif.out_key, bif.out_index} !== {e.found, e.key, e.idx})
            $display("FAIL b2b result%0d: got %b/%0d/%0d expected %b/%0d/%0d", got,
                     bif.out_found, bif.out_key, bif.out_index, e.found, e.key, e.idx);
          else passes++;
        end
        if (bif.out_ready) begin
          if (q.size() > 0) void'(q.pop_front());
          got++;
        end
      end
      held    = bif.out_valid & ~bif.out_ready;
      p_found = bif.out_found;
      p_key   = bif.out_key;
      p_idx   = bif.out_index;
      if (bif.in_valid && bif.in_ready) begin
        q.push_back(model(reqs[sent]));
        sent++;
      end
    end
    checks++; if (got !== 5) $display("FAIL b2b result count: got %0d expected 5", got); else passes++;
    checks++; if (q.size() !== 0) $display("FAIL b2b leftover: got %0d expected 0", q.size()); else passes++;
    bif.out_ready = 1'b1;
  endtask

  task automatic test_random_traffic();
    res_t q [$];
    res_t e;
    req_t cur;
    logic held;
    logic       p_found;
    logic [7:0] p_key;
    logic [2:0] p_idx;
    int   accepted;
    int   got;
    held = 1'b0;
    p_found = 1'b0; p_key = '0; p_idx = '0;
    accepted = 0;
    got = 0;
    for (int c = 0; c < 400; c++) begin
      @(posedge clk); #1;
      bif.out_ready = (c >= 380) ? 1'b1 : ($urandom_range(0, 3) != 0);
      cur = rand_req();
      drive(cur, (c < 370) ? ($urandom_range(0, 3) != 0) : 1'b0);
      #1;
      checks++;
      if (bif.in_ready !== ~(bif.out_valid & ~bif.out_ready))
        $display("FAIL rnd in_ready c%0d: got %b expected %b", c, bif.in_ready, ~(bif.out_valid & ~bif.out_ready));
      else passes++;
      if (held) begin
        checks++;
        if ({bif.out_valid, bif.out_found, bif.out_key, bif.out_index} !== {1'b1, p_found, p_key, p_idx})
          $display("FAIL rnd hold c%0d: got %b/%0d/%0d expected %b/%0d/%0d", c,
                   bif.out_found, bif.out_key, bif.out_index, p_found, p_key, p_idx);
        else passes++;
      end
      if (bif.out_valid === 1'b1) begin
        checks++;
        if (q.size() == 0) $display("FAIL rnd unexpected result c%0d: got key %0d expected none", c, bif.out_key);
        else begin
          e = q[0];
          if ({bif.out_found, bif.out_key, bif.out_index} !== {e.found, e.key, e.idx})
            $display("FAIL rnd result%0d: got %b/%0d/%0d expected %b/%0d/%0d", got,
                     bif.out_found, bif.out_key, bif.out_index, e.found, e.key, e.idx);
          else passes++;
        end
        if (bif.out_ready) begin
          if (q.size() > 0) void'(q.pop_front());
          got++;
        end
      end
      held    = bif.out_valid & ~bif.out_ready;
      p_found = bif.out_found;
      p_key   = bif.out_key;
      p_idx   = bif.out_index;
      if (bif.in_valid && bif.in_ready) begin
        q.push_back(model(cur));
        accepted++;
      end
    end
    checks++; if (got !== accepted) $display("FAIL rnd result count: got %0d expected %0d", got, accepted); else passes++;
    checks++; if (q.size() !== 0) $display("FAIL rnd leftover: got %0d expected 0", q.size()); else passes++;
  endtask

  initial begin
    checks = 0;
    passes = 0;
    rst_n  = 1'b0;
    bif.out_ready = 1'b1;
    drive(rand_req(), 1'b0);
    test_reset();
    test_directed();
    test_back_to_back();
    test_random_traffic();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
